// File: rtl/sync_position_tracker.sv
// sync_position_tracker
//   Recovers the pixel (h_pos) and line (v_pos) position of incoming video
//   from raw h_sync/v_sync pulses, entirely in the clk domain. Each sync input
//   is synchronised and edge-detected. A pixel counter and a line counter are
//   run from the resulting events, and registered position, active-video,
//   strobe and lock outputs are produced from them.
//
// Ports
//   clk          in   1        system clock, rising edge
//   rst          in   1        asynchronous, active-high reset
//   pix_en       in   1        pixel-rate clock enable
//   h_sync       in   1        raw horizontal sync (asynchronous)
//   v_sync       in   1        raw vertical sync (asynchronous)
//   h_pos        out  H_WIDTH  pixel index inside the active area, else 0
//   v_pos        out  V_WIDTH  line index inside the active area, else 0
//   active       out  1        inside the active area while locked
//   line_start   out  1        1-clk pulse per detected h_sync leading edge
//   frame_start  out  1        1-clk pulse per detected v_sync leading edge
//   line_total   out  V_WIDTH  line count of the last completed frame
//   locked       out  1        last frame was long enough, no saturation
module sync_position_tracker #(
    parameter int unsigned H_WIDTH         = 10,
    parameter int unsigned V_WIDTH         = 10,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned SYNC_ACTIVE_LOW = 1,
    parameter int unsigned H_START         = 144,
    parameter int unsigned V_START         = 35,
    parameter int unsigned H_ACTIVE        = 640,
    parameter int unsigned V_ACTIVE        = 480
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pix_en,
    input  logic               h_sync,
    input  logic               v_sync,
    output logic [H_WIDTH-1:0] h_pos,
    output logic [V_WIDTH-1:0] v_pos,
    output logic               active,
    output logic               line_start,
    output logic               frame_start,
    output logic [V_WIDTH-1:0] line_total,
    output logic               locked
);

    localparam logic [H_WIDTH-1:0] H_MAX = '1;
    localparam logic [V_WIDTH-1:0] V_MAX = '1;
    localparam int unsigned        H_END = H_START + H_ACTIVE;
    localparam int unsigned        V_END = V_START + V_ACTIVE;

    logic                   hs_norm;
    logic                   vs_norm;
    logic [SYNC_STAGES-1:0] hs_sync_q;
    logic [SYNC_STAGES-1:0] vs_sync_q;
    logic                   hs_prev;
    logic                   vs_prev;
    logic                   hs_evt;
    logic                   vs_evt;
    logic [H_WIDTH-1:0]     h_cnt;
    logic [V_WIDTH-1:0]     v_cnt;
    logic                   h_sat;
    logic                   v_sat;
    logic                   in_area;

    // Normalise polarity so that 1 always means "sync pulse"; the reset value
    // of the synchroniser then reads as the idle level.
    assign hs_norm = (SYNC_ACTIVE_LOW != 0) ? ~h_sync : h_sync;
    assign vs_norm = (SYNC_ACTIVE_LOW != 0) ? ~v_sync : v_sync;

    // Synchronisers plus registered leading-edge detectors
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_sync_q <= '0;
            vs_sync_q <= '0;
            hs_prev   <= 1'b0;
            vs_prev   <= 1'b0;
            hs_evt    <= 1'b0;
            vs_evt    <= 1'b0;
        end else begin
            hs_sync_q <= {hs_sync_q[SYNC_STAGES-2:0], hs_norm};
            vs_sync_q <= {vs_sync_q[SYNC_STAGES-2:0], vs_norm};
            hs_prev   <= hs_sync_q[SYNC_STAGES-1];
            vs_prev   <= vs_sync_q[SYNC_STAGES-1];
            hs_evt    <= hs_sync_q[SYNC_STAGES-1] & ~hs_prev;
            vs_evt    <= vs_sync_q[SYNC_STAGES-1] & ~vs_prev;
        end
    end

    assign h_sat = (h_cnt == H_MAX);
    assign v_sat = (v_cnt == V_MAX);

    // Active window decoded from the current counters and lock state
    assign in_area = locked
                   && (32'(h_cnt) >= H_START) && (32'(h_cnt) < H_END)
                   && (32'(v_cnt) >= V_START) && (32'(v_cnt) < V_END);

    // Pixel and line counters, both saturating
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            if (hs_evt) begin
                h_cnt <= '0;
            end else if (pix_en && !h_sat) begin
                h_cnt <= h_cnt + H_WIDTH'(1);
            end

            // A frame edge wins over a coincident line edge
            if (vs_evt) begin
                v_cnt <= '0;
            end else if (hs_evt && !v_sat) begin
                v_cnt <= v_cnt + V_WIDTH'(1);
            end
        end
    end

    // Frame measurement and lock; a saturated counter means the timing is
    // not trustworthy, so it overrides any frame-edge decision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_total <= '0;
            locked     <= 1'b0;
        end else begin
            if (vs_evt) begin
                line_total <= v_cnt;
            end

            if (h_sat || v_sat) begin
                locked <= 1'b0;
            end else if (vs_evt) begin
                locked <= (32'(v_cnt) >= V_END);
            end
        end
    end

    // Registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            active      <= 1'b0;
            h_pos       <= '0;
            v_pos       <= '0;
        end else begin
            line_start  <= hs_evt;
            frame_start <= vs_evt;
            active      <= in_area;
            h_pos       <= in_area ? (h_cnt - H_WIDTH'(H_START)) : '0;
            v_pos       <= in_area ? (v_cnt - V_WIDTH'(V_START)) : '0;
        end
    end

endmodule

// File: tb/tb_sync_position_tracker.sv
// Testbench for sync_position_tracker: a scaled-down timing (20 ticks/line,
// 12 lines/frame) drives an active-low and an active-high instance with the
// same logical sync pattern; both are compared every clock against a
// behavioural model, plus a vector table and directed frame-level checks.
module tb_sync_position_tracker;

    localparam int HW      = 6;
    localparam int VW      = 5;
    localparam int SS      = 2;
    localparam int HST     = 5;
    localparam int HAC     = 8;
    localparam int VST     = 3;
    localparam int VAC     = 6;
    localparam int H_TOTAL = 20;
    localparam int HS_W    = 3;
    localparam int VS_W    = 2;
    localparam int V_TOTAL = 12;
    localparam int HMAX    = (1 << HW) - 1;
    localparam int VMAX    = (1 << VW) - 1;

    logic clk       = 1'b0;
    logic rst       = 1'b1;
    logic pix_en    = 1'b0;
    logic h_sync_lo = 1'b1;
    logic v_sync_lo = 1'b1;
    logic h_sync_hi = 1'b0;
    logic v_sync_hi = 1'b0;

    logic [HW-1:0] lo_h_pos,  hi_h_pos;
    logic [VW-1:0] lo_v_pos,  hi_v_pos;
    logic          lo_active, hi_active;
    logic          lo_line_start, hi_line_start;
    logic          lo_frame_start, hi_frame_start;
    logic [VW-1:0] lo_line_total, hi_line_total;
    logic          lo_locked, hi_locked;

    sync_position_tracker #(
        .H_WIDTH(HW), .V_WIDTH(VW), .SYNC_STAGES(SS), .SYNC_ACTIVE_LOW(1),
        .H_START(HST), .V_START(VST), .H_ACTIVE(HAC), .V_ACTIVE(VAC)
    ) u_dut_lo (
        .clk(clk), .rst(rst), .pix_en(pix_en), .h_sync(h_sync_lo), .v_sync(v_sync_lo),
        .h_pos(lo_h_pos), .v_pos(lo_v_pos), .active(lo_active),
        .line_start(lo_line_start), .frame_start(lo_frame_start),
        .line_total(lo_line_total), .locked(lo_locked)
    );

    sync_position_tracker #(
        .H_WIDTH(HW), .V_WIDTH(VW), .SYNC_STAGES(SS), .SYNC_ACTIVE_LOW(0),
        .H_START(HST), .V_START(VST), .H_ACTIVE(HAC), .V_ACTIVE(VAC)
    ) u_dut_hi (
        .clk(clk), .rst(rst), .pix_en(pix_en), .h_sync(h_sync_hi), .v_sync(v_sync_hi),
        .h_pos(hi_h_pos), .v_pos(hi_v_pos), .active(hi_active),
        .line_start(hi_line_start), .frame_start(hi_frame_start),
        .line_total(hi_line_total), .locked(hi_locked)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit hs;
        bit vs;
        bit pe;
        bit ls;
        bit fs;
        int lt;
    } tv_t;

    int checks = 0;
    int errors = 0;

    // Reference model state (positions as plain integers)
    int          m_h, m_v, m_lt, m_hp, m_vp;
    bit          m_locked, m_act, m_ls, m_fs;
    bit [SS+2:0] h_hist, v_hist;
    bit          cur_hs, cur_vs, cur_pe;

    // Frame-level expectations and active-area tracking
    int fs_seen = 0;
    bit exp_arm = 1'b0;
    int exp_at, exp_lt;
    bit exp_lock;
    bit trk_seen;
    int trk_first_h, trk_first_v, trk_last_h, trk_last_v;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, want, $time);
            if (errors >= 40) begin
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
        end
    endtask

    function automatic logic [31:0] pack_out(input logic act, input logic ls, input logic fs,
                                             input logic lk, input logic [VW-1:0] lt,
                                             input logic [HW-1:0] hp, input logic [VW-1:0] vp);
        return 32'({act, ls, fs, lk, lt, hp, vp});
    endfunction

    task automatic model_clear();
        m_h = 0; m_v = 0; m_lt = 0; m_hp = 0; m_vp = 0;
        m_locked = 1'b0; m_act = 1'b0; m_ls = 1'b0; m_fs = 1'b0;
        h_hist = '0; v_hist = '0;
    endtask

    // One clock of the model: a sync event is a pulse sample seen SS+1 clocks
    // ago whose predecessor was idle; outputs reflect the positions held
    // before this edge.
    task automatic model_step();
        bit eh, ev, in_area;
        if (rst) begin
            model_clear();
            return;
        end
        h_hist = {h_hist[SS+1:0], cur_hs};
        v_hist = {v_hist[SS+1:0], cur_vs};
        eh = h_hist[SS+1] && !h_hist[SS+2];
        ev = v_hist[SS+1] && !v_hist[SS+2];

        in_area = m_locked && (m_h >= HST) && (m_h < HST + HAC) && (m_v >= VST) && (m_v < VST + VAC);
        m_act = in_area;
        m_hp  = in_area ? m_h - HST : 0;
        m_vp  = in_area ? m_v - VST : 0;
        m_ls  = eh;
        m_fs  = ev;

        if (m_h == HMAX || m_v == VMAX) m_locked = 1'b0;
        else if (ev)                    m_locked = (m_v >= VST + VAC);
        if (ev) m_lt = m_v;

        if (eh) m_h = 0;
        else    m_h = (m_h + int'(cur_pe) > HMAX) ? HMAX : m_h + int'(cur_pe);
        if (ev) m_v = 0;
        else    m_v = (m_v + int'(eh) > VMAX) ? VMAX : m_v + int'(eh);
    endtask

    // Drive one clock of logical sync levels, then compare both instances
    task automatic tick(input bit hs, input bit vs, input bit pe);
        logic [31:0] want;
        cur_hs = hs; cur_vs = vs; cur_pe = pe;
        h_sync_lo = ~hs; v_sync_lo = ~vs;
        h_sync_hi = hs;  v_sync_hi = vs;
        pix_en = pe;
        @(posedge clk);
        model_step();
        @(negedge clk);
        want = pack_out(m_act, m_ls, m_fs, m_locked, VW'(m_lt), HW'(m_hp), VW'(m_vp));
        chk("model_lo", pack_out(lo_active, lo_line_start, lo_frame_start, lo_locked,
                                 lo_line_total, lo_h_pos, lo_v_pos), want);
        chk("model_hi", pack_out(hi_active, hi_line_start, hi_frame_start, hi_locked,
                                 hi_line_total, hi_h_pos, hi_v_pos), want);
        if (m_fs) begin
            fs_seen++;
            if (exp_arm && fs_seen == exp_at) begin
                chk("fs_line_total", 32'(lo_line_total), 32'(exp_lt));
                chk("fs_locked", 32'(lo_locked), 32'(exp_lock));
                exp_arm = 1'b0;
            end
        end
        if (lo_active) begin
            if (!trk_seen) begin
                trk_seen    = 1'b1;
                trk_first_h = int'(lo_h_pos);
                trk_first_v = int'(lo_v_pos);
            end
            trk_last_h = int'(lo_h_pos);
            trk_last_v = int'(lo_v_pos);
        end
    endtask

    // One pixel tick, preceded by 0..1 clocks with pix_en low
    task automatic px(input bit hs, input bit vs);
        int idle;
        idle = int'($urandom_range(0, 1));
        repeat (idle) tick(hs, vs, 1'b0);
        tick(hs, vs, 1'b1);
    endtask

    task automatic trk_reset();
        trk_seen = 1'b0;
        trk_first_h = -1; trk_first_v = -1; trk_last_h = -1; trk_last_v = -1;
    endtask

    task automatic trk_check_window();
        chk("active_seen", 32'(trk_seen), 32'd1);
        chk("first_active_pos", 32'({trk_first_h[15:0], trk_first_v[15:0]}), 32'd0);
        chk("last_active_pos", 32'({trk_last_h[15:0], trk_last_v[15:0]}),
            32'(((HAC - 1) << 16) | (VAC - 1)));
    endtask

    // The v_sync leading edge of the next frame sits two ticks before its
    // first line, so it precedes that line's h_sync edge.
    task automatic lead_in();
        px(1'b0, 1'b1);
        px(1'b0, 1'b1);
    endtask

    // One frame; h pulses suppressed on lines hold_lo..hold_hi. When armed, the
    // frame_start ending this frame must report a_lt / a_lock.
    task automatic send_frame(input int nlines, input int hold_lo, input int hold_hi,
                              input bit arm, input int a_lt, input bit a_lock);
        for (int ln = 0; ln < nlines; ln++) begin
            if (arm && ln == 1) begin
                chk("fs_pending", 32'(exp_arm), 32'd0);
                exp_arm  = 1'b1;
                exp_at   = fs_seen + 1;
                exp_lt   = a_lt;
                exp_lock = a_lock;
            end
            if (ln == hold_lo) chk("locked_before_hold", 32'(lo_locked), 32'd1);
            if (ln == hold_hi + 1 && hold_hi >= hold_lo) chk("locked_after_sat", 32'(lo_locked), 32'd0);
            for (int t = 0; t < H_TOTAL; t++) begin
                bit hs, vs;
                hs = (t < HS_W) && !(ln >= hold_lo && ln <= hold_hi);
                vs = (ln < VS_W) || (ln == nlines - 1 && t >= H_TOTAL - 2);
                px(hs, vs);
            end
        end
    endtask

    initial begin
        tv_t tbl[16];
        for (int i = 0; i < 16; i++) tbl[i] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0};
        tbl[1].hs  = 1'b1;
        tbl[4].hs  = 1'b1; tbl[4].ls = 1'b1;
        tbl[7].hs  = 1'b1; tbl[7].vs = 1'b1; tbl[7].ls = 1'b1;
        tbl[8].vs  = 1'b1;
        tbl[10].ls = 1'b1; tbl[10].fs = 1'b1;
        for (int i = 10; i < 15; i++) tbl[i].lt = 2;
        tbl[12].vs = 1'b1;
        tbl[15].fs = 1'b1;

        model_clear();
        trk_reset();

        // Reset state
        repeat (3) tick(1'b0, 1'b0, 1'b1);
        chk("reset_lo", pack_out(lo_active, lo_line_start, lo_frame_start, lo_locked,
                                 lo_line_total, lo_h_pos, lo_v_pos), 32'd0);
        chk("reset_hi", pack_out(hi_active, hi_line_start, hi_frame_start, hi_locked,
                                 hi_line_total, hi_h_pos, hi_v_pos), 32'd0);
        rst = 1'b0;

        // Edge latency, pulse width, coincident h/v edges, line_total capture
        for (int i = 0; i < 16; i++) begin
            tick(tbl[i].hs, tbl[i].vs, tbl[i].pe);
            chk($sformatf("table_lo[%0d]", i),
                32'({lo_line_start, lo_frame_start, lo_locked, lo_active, lo_line_total}),
                32'({tbl[i].ls, tbl[i].fs, 2'b00, VW'(tbl[i].lt)}));
            chk($sformatf("table_hi[%0d]", i),
                32'({hi_line_start, hi_frame_start, hi_locked, hi_active, hi_line_total}),
                32'({tbl[i].ls, tbl[i].fs, 2'b00, VW'(tbl[i].lt)}));
        end

        // Acquisition, active window, short frame, h and v saturation
        lead_in();
        send_frame(V_TOTAL, -1, -2, 1'b1, V_TOTAL, 1'b1);
        send_frame(V_TOTAL, -1, -2, 1'b0, 0, 1'b0);
        trk_reset();
        send_frame(V_TOTAL, -1, -2, 1'b0, 0, 1'b0);
        trk_check_window();
        send_frame(5, -1, -2, 1'b1, 5, 1'b0);
        trk_reset();
        send_frame(V_TOTAL, -1, -2, 1'b1, V_TOTAL, 1'b1);
        chk("no_active_after_short", 32'(trk_seen), 32'd0);
        send_frame(V_TOTAL, -1, -2, 1'b0, 0, 1'b0);
        send_frame(V_TOTAL, 3, 5, 1'b1, V_TOTAL - 3, 1'b1);
        send_frame(V_TOTAL, -1, -2, 1'b0, 0, 1'b0);
        send_frame(34, -1, -2, 1'b1, VMAX, 1'b0);
        send_frame(V_TOTAL, -1, -2, 1'b1, V_TOTAL, 1'b1);

        // Asynchronous reset in the middle of a line
        for (int ln = 0; ln < 4; ln++) begin
            for (int t = 0; t < ((ln == 3) ? 7 : H_TOTAL); t++) px(t < HS_W, 1'b0);
        end
        #2 rst = 1'b1;
        model_clear();
        #1;
        chk("async_reset_lo", pack_out(lo_active, lo_line_start, lo_frame_start, lo_locked,
                                       lo_line_total, lo_h_pos, lo_v_pos), 32'd0);
        chk("async_reset_hi", pack_out(hi_active, hi_line_start, hi_frame_start, hi_locked,
                                       hi_line_total, hi_h_pos, hi_v_pos), 32'd0);
        repeat (3) tick(1'b0, 1'b0, 1'b1);
        rst = 1'b0;

        lead_in();
        send_frame(V_TOTAL, -1, -2, 1'b1, V_TOTAL, 1'b1);
        trk_reset();
        send_frame(V_TOTAL, -1, -2, 1'b0, 0, 1'b0);
        trk_check_window();
        repeat (8) px(1'b0, 1'b0);
        chk("fs_pending_end", 32'(exp_arm), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
